// File: rtl/calc2_port_requester.sv
// rtl/calc2_port_requester.sv - calc2 port initiator: 2-cycle operand issue, 4-tag in-order retire table.
// Optional per-tag watchdog enabled by defining CALC2_REQ_TIMEOUT_EN.
module calc2_port_requester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_data1,
  input  logic [31:0] op_data2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  dut_resp,
  input  logic [31:0] dut_data,
  input  logic [1:0]  dut_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_cmd,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic        rsp_timeout,
  output logic        err_unexp,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SEND2 = 1'b1;
  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_max
    $error("MAX_OUTSTANDING must be 1..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  logic [0:0]  state;
  logic [1:0]  wr_tag;
  logic [1:0]  rd_tag;
  logic [2:0]  count;
  logic [3:0]  t_valid;
  logic [3:0]  t_done;
  logic [3:0]  t_cmd   [4];
  logic [31:0] t_data2 [4];
  logic [1:0]  t_resp  [4];
  logic [31:0] t_data  [4];

  logic        accept;
  logic        retire;
  logic        cap_any;
  logic        cap_ok;
  logic        head_ok;
  logic [1:0]  rd_next;
  logic [1:0]  sent_tag;

  // op_ready looks at the pre-retire count, so a full table blocks accept even while retiring
  assign op_ready = (state == ST_IDLE) && (count < MAX_CNT);
  assign accept   = op_valid && op_ready;
  assign retire   = rsp_valid && rsp_ready;
  assign rd_next  = retire ? rd_tag + 2'd1 : rd_tag;
  assign sent_tag = wr_tag - 2'd1;
  assign cap_any  = (dut_resp != 2'd0);
  assign cap_ok   = cap_any && t_valid[dut_tag] && !t_done[dut_tag];
  assign head_ok  = t_valid[rd_next] && t_done[rd_next];
  assign busy     = (count != 3'd0) || (state == ST_SEND2);

`ifdef CALC2_REQ_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] t_cnt [4];
  logic [3:0] t_to;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_tag       <= 2'd0;
      rd_tag       <= 2'd0;
      count        <= 3'd0;
      t_valid      <= 4'd0;
      t_done       <= 4'd0;
      req_cmd_out  <= 4'd0;
      req_data_out <= 32'd0;
      req_tag_out  <= 2'd0;
      rsp_valid    <= 1'b0;
      rsp_cmd      <= 4'd0;
      rsp_resp     <= 2'd0;
      rsp_data     <= 32'd0;
      rsp_tag      <= 2'd0;
      err_unexp    <= 1'b0;
`ifdef CALC2_REQ_TIMEOUT_EN
      t_to         <= 4'd0;
      rsp_timeout  <= 1'b0;
`endif
    end else begin
      err_unexp <= cap_any && !cap_ok;
      count     <= count + {2'b00, accept} - {2'b00, retire};
      rd_tag    <= rd_next;

      rsp_valid <= head_ok;
      rsp_cmd   <= head_ok ? t_cmd[rd_next]  : 4'd0;
      rsp_resp  <= head_ok ? t_resp[rd_next] : 2'd0;
      rsp_data  <= head_ok ? t_data[rd_next] : 32'd0;
      rsp_tag   <= head_ok ? rd_next         : 2'd0;
`ifdef CALC2_REQ_TIMEOUT_EN
      rsp_timeout <= head_ok && t_to[rd_next];
`endif

      if (retire) begin
        t_valid[rd_tag] <= 1'b0;
        t_done[rd_tag]  <= 1'b0;
      end

`ifdef CALC2_REQ_TIMEOUT_EN
      // Watchdog expiry is written before capture so a response in the same cycle wins
      for (int i = 0; i < 4; i++) begin
        if (t_valid[i] && !t_done[i]) begin
          t_cnt[i] <= t_cnt[i] + 8'd1;
          if (t_cnt[i] + 8'd1 == TO_LIMIT) begin
            t_done[i] <= 1'b1;
            t_resp[i] <= 2'd3;
            t_data[i] <= 32'd0;
            t_to[i]   <= 1'b1;
          end
        end
      end
`endif

      if (cap_ok) begin
        t_done[dut_tag] <= 1'b1;
        t_resp[dut_tag] <= dut_resp;
        t_data[dut_tag] <= dut_data;
`ifdef CALC2_REQ_TIMEOUT_EN
        t_to[dut_tag]   <= 1'b0;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_cmd_out     <= op_cmd;
            req_data_out    <= op_data1;
            req_tag_out     <= wr_tag;
            t_cmd[wr_tag]   <= op_cmd;
            t_data2[wr_tag] <= op_data2;
            t_valid[wr_tag] <= 1'b1;
            t_done[wr_tag]  <= 1'b0;
`ifdef CALC2_REQ_TIMEOUT_EN
            t_cnt[wr_tag]   <= 8'd0;
            t_to[wr_tag]    <= 1'b0;
`endif
            wr_tag          <= wr_tag + 2'd1;
            state           <= ST_SEND2;
          end else begin
            req_cmd_out  <= 4'd0;
            req_data_out <= 32'd0;
            req_tag_out  <= 2'd0;
          end
        end
        default: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= t_data2[sent_tag];
          req_tag_out  <= 2'd0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
